// File: rtl/mem_access_pkg.sv
// Shared type definitions for the memory-access stage.
// common : data-bus request/response structs and the access-size encoding.
// pipes  : pipeline register structs, the stage FSM state type and the
//          misaligned-access exception codes.

package common;

   // Access size encoded as log2 of the byte count
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

endpackage

package pipes;
   import common::*;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } mem_state_t;

   // RISC-V cause codes; zero means no exception
   localparam logic [3:0] EXC_NONE           = 4'd0;
   localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

   typedef struct packed {
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      msize_t     msize;
      logic       memUnsigned;
      logic [3:0] exception;
   } ctl_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      ctl_t        ctl;
      logic [4:0]  dst;
      logic [63:0] srcb;
      logic [63:0] alu_out;
   } execute_data_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      ctl_t        ctl;
      logic [4:0]  dst;
      logic [63:0] alu_out;
      logic [63:0] rdata;
   } memory_data_t;

   // True when the low address bits are not a multiple of the access size
   function automatic logic is_misaligned(input logic [2:0] offset, input msize_t size);
      logic result;
      result = 1'b0;
      case (size)
         MSIZE1:  result = 1'b0;
         MSIZE2:  result = offset[0];
         MSIZE4:  result = |offset[1:0];
         default: result = |offset[2:0];
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane alignment for the memory stage (purely combinational).
// Store path shifts data and strobes into the addressed lanes; load path
// shifts the returned doubleword down and sign- or zero-extends it.

module mem_align
   import common::*;
(
   input  logic [2:0]  offset,
   input  msize_t      size,
   input  logic        is_unsigned,
   input  logic [63:0] store_data,
   input  logic [63:0] load_data,
   output logic [63:0] wdata,
   output logic [7:0]  strobe,
   output logic [63:0] rdata
);

   logic [5:0]  shamt;
   logic [7:0]  strobe_base;
   logic [63:0] raw;

   assign shamt = {offset, 3'b000};

   // Store lanes: lanes shifted past byte 7 are simply dropped
   always_comb begin
      strobe_base = 8'hFF;
      case (size)
         MSIZE1:  strobe_base = 8'h01;
         MSIZE2:  strobe_base = 8'h03;
         MSIZE4:  strobe_base = 8'h0F;
         default: strobe_base = 8'hFF;
      endcase
      strobe = strobe_base << offset;
      wdata  = store_data << shamt;
   end

   // Load extraction: bring the addressed bytes to bit 0, then extend
   always_comb begin
      raw   = load_data >> shamt;
      rdata = raw;
      case (size)
         MSIZE1:  rdata = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         MSIZE2:  rdata = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         MSIZE4:  rdata = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default: rdata = raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage of the 64-bit pipeline. Issues exactly one data-bus
// transaction per load/store, holds the pipe while the bus is busy, and
// drains transactions orphaned by a flush.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned accesses
// instead of issuing them.

module mem_access
   import common::*;
   import pipes::*;
#(
   parameter int ADDR_W = 64
)
(
   input  logic          clk,
   input  logic          resetn,
   input  execute_data_t dataE,
   input  logic          stall_in,
   input  logic          flush,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp,
   output memory_data_t  dataM,
   output logic          stallM
);

   mem_state_t  state_q, state_d;
   logic [63:0] rdata_q, rdata_d;
   dbus_req_t   req_q, req_d;

   logic        mem_op;
   logic        misaligned;
   logic        issue_ok;
   logic        kill;
   logic [63:0] st_data;
   logic [7:0]  st_strobe;
   logic [63:0] align_rdata;
   logic [63:0] load_value;
   logic [63:0] rdata_out;
   dbus_req_t   issue_req;

   mem_align u_align (
      .offset      (dataE.alu_out[2:0]),
      .size        (dataE.ctl.msize),
      .is_unsigned (dataE.ctl.memUnsigned),
      .store_data  (dataE.srcb),
      .load_data   (dresp.data),
      .wdata       (st_data),
      .strobe      (st_strobe),
      .rdata       (align_rdata)
   );

   assign mem_op = dataE.valid & (dataE.ctl.memRead | dataE.ctl.memWrite);

`ifdef MEM_MISALIGN_CHECK_EN
   assign misaligned = mem_op & is_misaligned(dataE.alu_out[2:0], dataE.ctl.msize);
`else
   assign misaligned = 1'b0;
`endif

   assign issue_ok   = mem_op & ~misaligned & ~flush;
   assign load_value = dataE.ctl.memRead ? align_rdata : 64'd0;

   // Request as built from the instruction currently in the stage
   always_comb begin
      issue_req        = '0;
      issue_req.valid  = 1'b1;
      issue_req.addr   = 64'(dataE.alu_out[ADDR_W-1:0]);
      issue_req.size   = dataE.ctl.msize;
      issue_req.strobe = st_strobe;
      issue_req.data   = st_data;
   end

   // Next-state, bus request and stall; the completing cycle never stalls so the
   // instruction leaves M before it could be issued a second time
   always_comb begin
      state_d    = state_q;
      rdata_d    = rdata_q;
      req_d      = req_q;
      dreq       = issue_req;
      dreq.valid = 1'b0;
      stallM     = 1'b0;
      rdata_out  = 64'd0;
      kill       = flush;
      unique case (state_q)
         S_IDLE: begin
            if (issue_ok) begin
               dreq.valid = 1'b1;
               req_d      = issue_req;
               if (dresp.data_ok) begin
                  rdata_out = load_value;
                  rdata_d   = load_value;
                  if (stall_in) state_d = S_DONE;
               end else begin
                  stallM  = 1'b1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            dreq       = req_q;
            dreq.valid = 1'b1;
            if (flush) begin
               stallM  = 1'b1;
               state_d = dresp.data_ok ? S_IDLE : S_DRAIN;
            end else if (dresp.data_ok) begin
               rdata_out = load_value;
               rdata_d   = load_value;
               state_d   = stall_in ? S_DONE : S_IDLE;
            end else begin
               stallM = 1'b1;
            end
         end
         S_DONE: begin
            rdata_out = rdata_q;
            if (flush || !stall_in) state_d = S_IDLE;
         end
         S_DRAIN: begin
            dreq       = req_q;
            dreq.valid = 1'b1;
            stallM     = 1'b1;
            kill       = 1'b1;
            if (dresp.data_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (!resetn) begin
         dreq.valid = 1'b0;
         stallM     = 1'b0;
      end
   end

   // State, captured load data and the in-flight request
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         rdata_q <= 64'd0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
      end
   end

   // Forward the instruction to writeback with its load value and any trap
   always_comb begin
      dataM         = '0;
      dataM.valid   = dataE.valid & ~kill;
      dataM.pc      = dataE.pc;
      dataM.ctl     = dataE.ctl;
      dataM.dst     = dataE.dst;
      dataM.alu_out = dataE.alu_out;
      dataM.rdata   = rdata_out;
      if (misaligned) begin
         dataM.ctl.exception = dataE.ctl.memWrite ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus requests and
// writeback results, independent monitors pop and compare them.

module tb_mem_access;
   import common::*;
   import pipes::*;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          stall_in = 1'b0;
   logic          flush = 1'b0;
   execute_data_t dataE;
   dbus_req_t     dreq;
   dbus_resp_t    dresp;
   memory_data_t  dataM;
   logic          stallM;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic [63:0] pc;
      logic [4:0]  dst;
      logic [63:0] rdata;
      logic [3:0]  exc;
   } wbExp_t;

   typedef struct {
      logic [63:0] addr;
      logic [1:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } busExp_t;

   wbExp_t    wbQ[$];
   busExp_t   busQ[$];
   wbExp_t    wbCur;
   busExp_t   busCur;
   dbus_req_t heldReq;
   bit        inTxn = 0;

   // Free-running clock
   always #5 clk = ~clk;

   mem_access #(.ADDR_W(64)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .dataE    (dataE),
      .stall_in (stall_in),
      .flush    (flush),
      .dreq     (dreq),
      .dresp    (dresp),
      .dataM    (dataM),
      .stallM   (stallM)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic execute_data_t mkInstr(input logic [63:0] pc, input logic rd, input logic wr,
                                             input msize_t sz, input logic uns, input logic [63:0] addr,
                                             input logic [63:0] srcb, input logic [4:0] dst);
      execute_data_t e;
      e                 = '0;
      e.valid           = 1'b1;
      e.pc              = pc;
      e.ctl.regWrite    = ~wr;
      e.ctl.memRead     = rd;
      e.ctl.memWrite    = wr;
      e.ctl.msize       = sz;
      e.ctl.memUnsigned = uns;
      e.dst             = dst;
      e.srcb            = srcb;
      e.alu_out         = addr;
      return e;
   endfunction

   task automatic expectWb(input logic [63:0] pc, input logic [4:0] dst, input logic [63:0] rdata, input logic [3:0] exc);
      wbExp_t x;
      x.pc = pc; x.dst = dst; x.rdata = rdata; x.exc = exc;
      wbQ.push_back(x);
   endtask

   task automatic expectBus(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe, input logic [63:0] data);
      busExp_t x;
      x.addr = addr; x.size = size; x.strobe = strobe; x.data = data;
      busQ.push_back(x);
   endtask

   // Drive one instruction until the M/W register accepts it (or it is gone)
   task automatic applyStimulus(input execute_data_t e, input int lat, input logic [63:0] busData,
                                input int holdCycles, input int flushAt, input int expStalls, input string name);
      int cyc    = 0;
      int held   = 0;
      int stalls = 0;
      bit done   = 0;
      dataE = e;
      while (!done && cyc < 40) begin
         dresp.data_ok = (cyc == lat);
         dresp.addr_ok = (cyc == 0);
         dresp.data    = (cyc == lat) ? busData : 64'hA5A5_A5A5_A5A5_A5A5;
         flush         = (cyc == flushAt);
         stall_in      = (cyc >= lat) && (held < holdCycles);
         if (stall_in) held++;
         @(negedge clk);
         if (stallM) stalls++;
         if (flushAt >= 0 && cyc >= flushAt) checkOutput({name, "_flush_valid"}, 64'(dataM.valid), 64'd0);
         if (cyc > lat && stall_in) checkOutput({name, "_done_dreq_valid"}, 64'(dreq.valid), 64'd0);
         if (!stallM && !stall_in) done = 1;
         @(posedge clk);
         #1;
         if (flush) dataE = '0;
         cyc++;
      end
      flush         = 1'b0;
      stall_in      = 1'b0;
      dresp.data_ok = 1'b0;
      dresp.addr_ok = 1'b0;
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s_timeout: got no completion expected completion within 40 cycles", name);
      end
      checkOutput({name, "_stalls"}, 64'(stalls), 64'(expStalls));
   endtask

   // Writeback monitor: compares every result the M/W register accepts
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && dataM.valid && !stallM && !stall_in) begin
            if (wbQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL wb_unexpected: got pc %h expected no result", dataM.pc);
            end else begin
               wbCur = wbQ.pop_front();
               checkOutput("wb_pc", dataM.pc, wbCur.pc);
               checkOutput("wb_dst", 64'(dataM.dst), 64'(wbCur.dst));
               checkOutput("wb_rdata", dataM.rdata, wbCur.rdata);
               checkOutput("wb_exc", 64'(dataM.ctl.exception), 64'(wbCur.exc));
            end
         end
      end
   end

   // Bus monitor: checks each new transaction and that it stays stable
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            inTxn = 0;
         end else if (dreq.valid) begin
            if (!inTxn) begin
               if (busQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL bus_unexpected: got request addr %h expected no request", dreq.addr);
               end else begin
                  busCur = busQ.pop_front();
                  checkOutput("bus_addr", dreq.addr, busCur.addr);
                  checkOutput("bus_size", 64'(dreq.size), 64'(busCur.size));
                  checkOutput("bus_strobe", 64'(dreq.strobe), 64'(busCur.strobe));
                  checkOutput("bus_data", dreq.data, busCur.data);
               end
               heldReq = dreq;
            end else begin
               checkOutput("bus_hold_addr", dreq.addr, heldReq.addr);
               checkOutput("bus_hold_data", dreq.data, heldReq.data);
               checkOutput("bus_hold_lanes", 64'({dreq.size, dreq.strobe}), 64'({heldReq.size, heldReq.strobe}));
            end
            inTxn = !dresp.data_ok;
         end else begin
            inTxn = 0;
         end
      end
   end

   // Hard stop in case the stimulus ever wedges
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of test expected finish before 100us");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      dresp = '0;
      dataE = mkInstr(64'h0FC, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h1000, 64'd0, 5'd1);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_dreq_valid", 64'(dreq.valid), 64'd0);
      checkOutput("rst_stallM", 64'(stallM), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      dataE  = '0;
      @(posedge clk);
      #1;

      // sd, zero-stall completion
      expectBus(64'h1000, MSIZE8, 8'hFF, 64'h1122334455667788);
      expectWb(64'h100, 5'd0, 64'd0, 4'd0);
      applyStimulus(mkInstr(64'h100, 1'b0, 1'b1, MSIZE8, 1'b0, 64'h1000, 64'h1122334455667788, 5'd0),
                    0, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 0, "sd");

      // lb / lbu with three wait cycles
      expectBus(64'h1003, MSIZE1, 8'h08, 64'd0);
      expectWb(64'h104, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 4'd0);
      applyStimulus(mkInstr(64'h104, 1'b1, 1'b0, MSIZE1, 1'b0, 64'h1003, 64'd0, 5'd5),
                    3, 64'h0000_0000_8000_0000, 0, -1, 3, "lb");
      expectBus(64'h1003, MSIZE1, 8'h08, 64'd0);
      expectWb(64'h108, 5'd6, 64'h0000_0000_0000_0080, 4'd0);
      applyStimulus(mkInstr(64'h108, 1'b1, 1'b0, MSIZE1, 1'b1, 64'h1003, 64'd0, 5'd6),
                    3, 64'h0000_0000_8000_0000, 0, -1, 3, "lbu");

      // sh into the top lanes
      expectBus(64'h1006, MSIZE2, 8'hC0, 64'hBEEF_0000_0000_0000);
      expectWb(64'h10C, 5'd0, 64'd0, 4'd0);
      applyStimulus(mkInstr(64'h10C, 1'b0, 1'b1, MSIZE2, 1'b0, 64'h1006, 64'h0000_1234_0000_BEEF, 5'd0),
                    2, 64'd0, 0, -1, 2, "sh");

      // ld completing under downstream stall, held in DONE
      expectBus(64'h1008, MSIZE8, 8'hFF, 64'd0);
      expectWb(64'h110, 5'd7, 64'h8877_6655_4433_2211, 4'd0);
      applyStimulus(mkInstr(64'h110, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h1008, 64'd0, 5'd7),
                    1, 64'h8877_6655_4433_2211, 2, -1, 1, "ld");

      // lw flushed while waiting: drained, no writeback
      expectBus(64'h2000, MSIZE4, 8'h0F, 64'd0);
      applyStimulus(mkInstr(64'h114, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h2000, 64'd0, 5'd8),
                    4, 64'h1234_5678_9ABC_DEF0, 0, 2, 5, "lw_flush");

      // next instruction issues fresh
      expectBus(64'h2002, MSIZE2, 8'h0C, 64'd0);
      expectWb(64'h118, 5'd9, 64'hFFFF_FFFF_FFFF_8001, 4'd0);
      applyStimulus(mkInstr(64'h118, 1'b1, 1'b0, MSIZE2, 1'b0, 64'h2002, 64'd0, 5'd9),
                    0, 64'h0000_0000_8001_0000, 0, -1, 0, "lh");

      // non-memory instruction passes straight through
      expectWb(64'h11C, 5'd10, 64'd0, 4'd0);
      applyStimulus(mkInstr(64'h11C, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h1234, 64'd0, 5'd10),
                    99, 64'd0, 0, -1, 0, "alu");

      // lwu from the upper word
      expectBus(64'h1004, MSIZE4, 8'hF0, 64'd0);
      expectWb(64'h120, 5'd11, 64'h0000_0000_F000_0001, 4'd0);
      applyStimulus(mkInstr(64'h120, 1'b1, 1'b0, MSIZE4, 1'b1, 64'h1004, 64'd0, 5'd11),
                    1, 64'hF000_0001_0000_0000, 0, -1, 1, "lwu");

      // misaligned lw at 0x1002 and sw at 0x1006
`ifdef MEM_MISALIGN_CHECK_EN
      expectWb(64'h124, 5'd12, 64'd0, EXC_LOAD_MISALIGN);
      applyStimulus(mkInstr(64'h124, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h1002, 64'd0, 5'd12),
                    0, 64'h0000_8765_4321_0000, 0, -1, 0, "lw_mis");
      expectWb(64'h126, 5'd0, 64'd0, EXC_STORE_MISALIGN);
      applyStimulus(mkInstr(64'h126, 1'b0, 1'b1, MSIZE4, 1'b0, 64'h1006, 64'h0000_0000_CAFE_BABE, 5'd0),
                    0, 64'd0, 0, -1, 0, "sw_mis");
`else
      expectBus(64'h1002, MSIZE4, 8'h3C, 64'd0);
      expectWb(64'h124, 5'd12, 64'hFFFF_FFFF_8765_4321, 4'd0);
      applyStimulus(mkInstr(64'h124, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h1002, 64'd0, 5'd12),
                    0, 64'h0000_8765_4321_0000, 0, -1, 0, "lw_mis");
      expectBus(64'h1006, MSIZE4, 8'hC0, 64'hBABE_0000_0000_0000);
      expectWb(64'h126, 5'd0, 64'd0, 4'd0);
      applyStimulus(mkInstr(64'h126, 1'b0, 1'b1, MSIZE4, 1'b0, 64'h1006, 64'h0000_0000_CAFE_BABE, 5'd0),
                    0, 64'd0, 0, -1, 0, "sw_mis");
`endif

      // flush in IDLE: no request, no result
      applyStimulus(mkInstr(64'h128, 1'b0, 1'b1, MSIZE4, 1'b0, 64'h1000, 64'h55, 5'd0),
                    99, 64'd0, 0, 0, 0, "sw_flush");

      // reset while a load is waiting abandons it immediately
      expectBus(64'h3000, MSIZE4, 8'h0F, 64'd0);
      dataE = mkInstr(64'h12A, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h3000, 64'd0, 5'd14);
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("wait_stallM", 64'(stallM), 64'd1);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      @(negedge clk);
      checkOutput("rst_wait_dreq_valid", 64'(dreq.valid), 64'd0);
      checkOutput("rst_wait_stallM", 64'(stallM), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      dataE  = '0;
      @(negedge clk);
      checkOutput("post_rst_dreq_valid", 64'(dreq.valid), 64'd0);
      @(posedge clk);
      #1;

      // fresh load after the abandoned one
      expectBus(64'h1001, MSIZE1, 8'h02, 64'd0);
      expectWb(64'h12C, 5'd13, 64'h0000_0000_0000_00FF, 4'd0);
      applyStimulus(mkInstr(64'h12C, 1'b1, 1'b0, MSIZE1, 1'b1, 64'h1001, 64'd0, 5'd13),
                    0, 64'h0000_0000_0000_FF00, 0, -1, 0, "lbu_after_rst");

      dataE = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("wb_queue_empty", 64'(wbQ.size()), 64'd0);
      checkOutput("bus_queue_empty", 64'(busQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
